// File: rtl/drac_pkg.sv
// Shared drac datapath types: register index, 64-bit bus and scoreboard counter.
package drac_pkg;

    localparam int SB_CNT_W = 2;

    typedef logic [4:0]          reg_addr_t;
    typedef logic [63:0]         bus64_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage

// File: rtl/scoreboard_cnt.sv
// One pending-write counter: +inc, -dec (several writebacks per cycle), flush to zero,
// never wrapping below zero or above its maximum.
module scoreboard_cnt
    import drac_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W,
    parameter int DEC_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             inc_i,
    input  logic [DEC_W-1:0] dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_nxt_o
);

    localparam int SUM_W = CNT_W + DEC_W + 1;
    localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum   = SUM_W'(cnt_q) + SUM_W'(inc_i);
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (sum < SUM_W'(dec_i)) begin
            cnt_d = '0;
        end else if ((sum - SUM_W'(dec_i)) > MAX_EXT) begin
            cnt_d = '1;
        end else begin
            cnt_d = CNT_W'(sum - SUM_W'(dec_i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;

    // A writeback for a register with no outstanding writer means the pipeline lost track.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        flush_i || (SUM_W'(dec_i) <= sum));

endmodule

// File: rtl/scoreboard_bypass.sv
// RR-stage scoreboard: per-register pending-write counters, multi-port WB forwarding
// onto both operands, and the RAW / WAW-saturation issue stall.
module scoreboard_bypass
    import drac_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int DATA_W       = 64,
    parameter int NUM_WB_PORTS = 2,
    parameter int CNT_W        = SB_CNT_W
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           issue_valid_i,
    input  logic                           issue_we_i,
    input  logic [REG_ADDR_W-1:0]          issue_rd_i,
    input  logic [REG_ADDR_W-1:0]          issue_rs1_i,
    input  logic [REG_ADDR_W-1:0]          issue_rs2_i,
    input  logic                           issue_use_rs1_i,
    input  logic                           issue_use_rs2_i,
    input  logic [DATA_W-1:0]              rf_data1_i,
    input  logic [DATA_W-1:0]              rf_data2_i,
    input  logic [NUM_WB_PORTS-1:0]        wb_valid_i,
    input  logic [NUM_WB_PORTS*REG_ADDR_W-1:0] wb_rd_i,
    input  logic [NUM_WB_PORTS*DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0]              opnd1_o,
    output logic [DATA_W-1:0]              opnd2_o,
    output logic                           stall_o,
    output logic                           issue_fire_o,
    output logic                           pending_any_o
);

    localparam int DEC_W = $clog2(NUM_WB_PORTS + 1);
    localparam int CMP_W = CNT_W + DEC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_nxt;
    logic [NUM_REGS-1:0][DEC_W-1:0] dec;
    logic raw1, raw2, waw, stall, fire;
    logic pending_any_d, pending_any_q;

    // Returns {raw_stall, operand}; the highest-index matching port is the youngest producer.
    function automatic logic [DATA_W:0] resolve(
        input logic [REG_ADDR_W-1:0]              rs,
        input logic                               use_rs,
        input logic [DATA_W-1:0]                  rf,
        input logic [CNT_W-1:0]                   c,
        input logic [DEC_W-1:0]                   d,
        input logic [NUM_WB_PORTS-1:0]            wv,
        input logic [NUM_WB_PORTS*REG_ADDR_W-1:0] wrd,
        input logic [NUM_WB_PORTS*DATA_W-1:0]     wd
    );
        logic              hit;
        logic [DATA_W-1:0] fwd;
        logic              raw;
        logic [DATA_W-1:0] op;
        hit = 1'b0;
        fwd = '0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (wv[p] && (wrd[p*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
                hit = 1'b1;
                fwd = wd[p*DATA_W +: DATA_W];
            end
        end
        raw = 1'b0;
        op  = rf;
        if (rs == '0) begin
            op = '0;
        end else if (use_rs) begin
            if (hit) op = fwd;
            raw = CMP_W'(c) > CMP_W'(d);
        end
        return {raw, op};
    endfunction

    always_comb begin
        dec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (wb_valid_i[p] && (wb_rd_i[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))) begin
                    dec[r] = dec[r] + DEC_W'(1);
                end
            end
        end
    end

    always_comb begin
        {raw1, opnd1_o} = resolve(issue_rs1_i, issue_use_rs1_i, rf_data1_i,
                                  cnt[issue_rs1_i], dec[issue_rs1_i],
                                  wb_valid_i, wb_rd_i, wb_data_i);
        {raw2, opnd2_o} = resolve(issue_rs2_i, issue_use_rs2_i, rf_data2_i,
                                  cnt[issue_rs2_i], dec[issue_rs2_i],
                                  wb_valid_i, wb_rd_i, wb_data_i);
        // A full counter may still accept a new writer if one retires this cycle.
        waw   = issue_we_i && (issue_rd_i != '0) && (cnt[issue_rd_i] == CNT_MAX)
                && (dec[issue_rd_i] == '0);
        stall = issue_valid_i && (raw1 || raw2 || waw);
        fire  = issue_valid_i && !stall;
    end

    assign cnt[0]     = '0;
    assign cnt_nxt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        scoreboard_cnt #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flush_i   (flush_i),
            .inc_i     (fire && issue_we_i && (issue_rd_i == REG_ADDR_W'(r))),
            .dec_i     (dec[r]),
            .cnt_o     (cnt[r]),
            .cnt_nxt_o (cnt_nxt[r])
        );
    end

    assign pending_any_d = |cnt_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_any_q <= 1'b0;
        end else begin
            pending_any_q <= pending_any_d;
        end
    end

    assign stall_o       = stall;
    assign issue_fire_o  = fire;
    assign pending_any_o = pending_any_q;

endmodule

// File: tb/tb_scoreboard_bypass.sv
// Bench for scoreboard_bypass: directed hazard scenarios then random traffic,
// checked against a per-register outstanding-writer count model.
module tb_scoreboard_bypass;
    import drac_pkg::*;

    localparam int EW = 3 + 64 + 64;

    typedef struct packed {
        logic      valid;
        logic      we;
        logic      use1;
        logic      use2;
        logic      flush;
        reg_addr_t rd;
        reg_addr_t rs1;
        reg_addr_t rs2;
        bus64_t    rf1;
        bus64_t    rf2;
        logic [1:0] wbv;
        reg_addr_t wbrd0;
        reg_addr_t wbrd1;
        bus64_t    wbd0;
        bus64_t    wbd1;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_i = 1'b0;
    logic       issue_valid_i = 1'b0;
    logic       issue_we_i = 1'b0;
    reg_addr_t  issue_rd_i = '0;
    reg_addr_t  issue_rs1_i = '0;
    reg_addr_t  issue_rs2_i = '0;
    logic       issue_use_rs1_i = 1'b0;
    logic       issue_use_rs2_i = 1'b0;
    bus64_t     rf_data1_i = '0;
    bus64_t     rf_data2_i = '0;
    logic [1:0] wb_valid_i = '0;
    logic [9:0] wb_rd_i = '0;
    logic [127:0] wb_data_i = '0;
    bus64_t     opnd1_o, opnd2_o;
    logic       stall_o, issue_fire_o, pending_any_o;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mask_q[$];
    int mcnt[32];
    int checks = 0;
    int errors = 0;

    scoreboard_bypass dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush_i),
        .issue_valid_i   (issue_valid_i),
        .issue_we_i      (issue_we_i),
        .issue_rd_i      (issue_rd_i),
        .issue_rs1_i     (issue_rs1_i),
        .issue_rs2_i     (issue_rs2_i),
        .issue_use_rs1_i (issue_use_rs1_i),
        .issue_use_rs2_i (issue_use_rs2_i),
        .rf_data1_i      (rf_data1_i),
        .rf_data2_i      (rf_data2_i),
        .wb_valid_i      (wb_valid_i),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .opnd1_o         (opnd1_o),
        .opnd2_o         (opnd2_o),
        .stall_o         (stall_o),
        .issue_fire_o    (issue_fire_o),
        .pending_any_o   (pending_any_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bus64_t rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: an operand needs every outstanding writer of its register to retire now.
    function automatic void ref_operand(input reg_addr_t rs, input logic use_rs, input bus64_t rf,
                                        input stim_t s, input int m_rs,
                                        output bus64_t op, output logic care, output logic raw);
        op = rf;
        care = 1'b1;
        raw = 1'b0;
        if (rs == 0) begin
            op = '0;
        end else if (use_rs) begin
            if (mcnt[rs] > m_rs) begin
                raw = 1'b1;
                care = 1'b0;
            end else if (m_rs > 0) begin
                op = (s.wbv[1] && s.wbrd1 == rs) ? s.wbd1 : s.wbd0;
            end
        end
    endfunction

    // driver: apply one cycle of stimulus, push the expected response, advance the model
    task automatic drive(input stim_t s);
        int m[32];
        bus64_t op1, op2;
        logic c1, c2, raw1, raw2, waw, stall, fire, pend;
        flush_i = s.flush;
        issue_valid_i = s.valid;
        issue_we_i = s.we;
        issue_rd_i = s.rd;
        issue_rs1_i = s.rs1;
        issue_rs2_i = s.rs2;
        issue_use_rs1_i = s.use1;
        issue_use_rs2_i = s.use2;
        rf_data1_i = s.rf1;
        rf_data2_i = s.rf2;
        wb_valid_i = s.wbv;
        wb_rd_i = {s.wbrd1, s.wbrd0};
        wb_data_i = {s.wbd1, s.wbd0};

        for (int r = 0; r < 32; r++) m[r] = 0;
        if (s.wbv[0]) m[s.wbrd0]++;
        if (s.wbv[1]) m[s.wbrd1]++;
        ref_operand(s.rs1, s.use1, s.rf1, s, m[s.rs1], op1, c1, raw1);
        ref_operand(s.rs2, s.use2, s.rf2, s, m[s.rs2], op2, c2, raw2);
        waw = s.we && (s.rd != 0) && (mcnt[s.rd] == 3) && (m[s.rd] == 0);
        stall = s.valid && (raw1 || raw2 || waw);
        fire = s.valid && !stall;
        pend = 1'b0;
        for (int r = 0; r < 32; r++) if (mcnt[r] != 0) pend = 1'b1;
        exp_q.push_back({pend, stall, fire, op1, op2});
        mask_q.push_back({3'b111, {64{c1}}, {64{c2}}});

        @(posedge clk);
        for (int r = 1; r < 32; r++) begin
            if (s.flush) begin
                mcnt[r] = 0;
            end else begin
                mcnt[r] = mcnt[r] + ((fire && s.we && s.rd == r) ? 1 : 0) - m[r];
                if (mcnt[r] < 0) mcnt[r] = 0;
            end
        end
        #1;
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic do_issue(input reg_addr_t rd, input logic we, input reg_addr_t rs1, input logic u1,
                            input reg_addr_t rs2, input logic u2, input logic [1:0] wbv,
                            input reg_addr_t r0, input bus64_t d0, input reg_addr_t r1, input bus64_t d1);
        stim_t s;
        s = nop();
        s.valid = 1'b1; s.we = we; s.rd = rd;
        s.rs1 = rs1; s.use1 = u1; s.rs2 = rs2; s.use2 = u2;
        s.rf1 = rnd64(); s.rf2 = rnd64();
        s.wbv = wbv; s.wbrd0 = r0; s.wbd0 = d0; s.wbrd1 = r1; s.wbd1 = d1;
        drive(s);
    endtask

    task automatic do_wb(input logic [1:0] wbv, input reg_addr_t r0, input reg_addr_t r1, input logic fl);
        stim_t s;
        s = nop();
        s.wbv = wbv; s.wbrd0 = r0; s.wbd0 = rnd64(); s.wbrd1 = r1; s.wbd1 = rnd64();
        s.flush = fl;
        drive(s);
    endtask

    task automatic random_cycle();
        stim_t s;
        int avail[32];
        int r;
        for (int i = 0; i < 32; i++) avail[i] = mcnt[i];
        s = nop();
        s.valid = ($urandom_range(0, 3) != 0);
        s.we = $urandom_range(0, 1);
        s.rd = 5'($urandom_range(0, 7));
        s.rs1 = 5'($urandom_range(0, 7));
        s.rs2 = 5'($urandom_range(0, 7));
        s.use1 = ($urandom_range(0, 4) != 0);
        s.use2 = ($urandom_range(0, 4) != 0);
        s.rf1 = rnd64();
        s.rf2 = rnd64();
        s.flush = ($urandom_range(0, 39) == 0);
        r = $urandom_range(1, 7);
        if ($urandom_range(0, 2) != 0 && avail[r] > 0) begin
            s.wbv[0] = 1'b1; s.wbrd0 = 5'(r); s.wbd0 = rnd64(); avail[r]--;
        end
        r = $urandom_range(1, 7);
        if ($urandom_range(0, 2) != 0 && avail[r] > 0) begin
            s.wbv[1] = 1'b1; s.wbrd1 = 5'(r); s.wbd1 = rnd64(); avail[r]--;
        end
        drive(s);
    endtask

    // monitor / scoreboard: one expected entry per driven cycle
    initial begin
        logic [EW-1:0] e, mk, act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                mk = mask_q.pop_front();
                act = {pending_any_o, stall_o, issue_fire_o, opnd1_o, opnd2_o};
                checks++;
                if ((act & mk) !== (e & mk)) begin
                    errors++;
                    $display("FAIL rr_out t=%0t: got pend=%b stall=%b fire=%b op1=%h op2=%h, expected pend=%b stall=%b fire=%b op1=%h op2=%h (op1 checked=%b op2 checked=%b)",
                             $time, act[130], act[129], act[128], act[127:64], act[63:0],
                             e[130], e[129], e[128], e[127:64], e[63:0], mk[64], mk[0]);
                end
            end
        end
    end

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        chk("reset_pending", {63'd0, pending_any_o}, 64'd0);

        // reset mid-operation with two writers of x5 outstanding
        do_issue(5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_issue(5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("pending_before_reset", {63'd0, pending_any_o}, 64'd1);
        rst = 1'b1;
        #2;
        chk("pending_async_reset", {63'd0, pending_any_o}, 64'd0);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        do_issue(0, 0, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0);

        // single RAW bypass on x7
        do_issue(7, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_issue(0, 0, 7, 1, 0, 0, 2'b01, 7, 64'hDEAD, 0, 0);
        do_issue(0, 0, 7, 1, 0, 0, 2'b00, 0, 0, 0, 0);

        // unresolved RAW on x3, then resolved by port 1
        do_issue(3, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_issue(0, 0, 0, 0, 3, 1, 2'b00, 0, 0, 0, 0);
        do_issue(0, 0, 0, 0, 3, 1, 2'b10, 0, 0, 3, 64'h55);

        // two writers of x9 retiring on both ports together
        do_issue(9, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_issue(9, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_issue(0, 0, 9, 1, 0, 0, 2'b11, 9, 64'h1, 9, 64'h2);
        do_issue(0, 0, 9, 1, 0, 0, 2'b00, 0, 0, 0, 0);

        // WAW saturation on x4
        for (int i = 0; i < 4; i++) do_issue(4, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_issue(4, 1, 0, 0, 0, 0, 2'b01, 4, 64'h44, 0, 0);
        do_issue(4, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_wb(2'b11, 4, 4, 1'b0);
        do_wb(2'b01, 4, 0, 1'b0);

        // x0 never stalls or becomes pending
        for (int i = 0; i < 4; i++) do_issue(0, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0);

        // flush clears an outstanding writer
        do_issue(10, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        do_wb(2'b00, 0, 0, 1'b1);
        do_issue(0, 0, 10, 1, 0, 0, 2'b00, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++) random_cycle();

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
